// File: rtl/common_types_pkg.sv
// Shared types for the multi-port RAM: requester-visible status, controller
// states and the supported requester count.
package common_types_pkg;

  typedef enum logic [1:0] {
    RAM_IDLE = 2'd0,
    RAM_WAIT = 2'd1,
    RAM_DONE = 2'd2
  } ram_state_t;

  typedef enum logic [1:0] {
    CTRL_IDLE = 2'd0,
    CTRL_BUSY = 2'd1,
    CTRL_DONE = 2'd2
  } ctrl_state_t;

  localparam int NPORTS_MAX = 8;

endpackage

// File: rtl/ram_mport_array.sv
// Single-port, byte-writable, read-first word store with a LAT+1 cycle read
// pipeline.
module ram_mport_array #(
  parameter int    RAM_SIZE  = 16384,
  parameter int    LAT       = 0,
  localparam int   AW        = $clog2(RAM_SIZE)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [RAM_SIZE];
  logic [31:0] rd_q  [LAT+1];

  // Stage 0 captures the old word before the lanes update (read-first).
  always_ff @(posedge clk) begin
    if (en_i) begin
      rd_q[0] <= mem_q[idx_i];
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    for (int i = 1; i <= LAT; i++) begin
      rd_q[i] <= rd_q[i-1];
    end
  end

  assign rdata_o = rd_q[LAT];

endmodule

// File: rtl/ram_mport.sv
// Multi-port front end: arbitrates NPORTS requesters onto one array.
// Define RAM_MPORT_FIXED_PRIO_EN for fixed priority instead of round-robin.
module ram_mport
  import common_types_pkg::*;
#(
  parameter int NPORTS   = 2,
  parameter int RAM_SIZE = 16384,
  parameter int LAT      = 0
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [NPORTS-1:0]        ren,
  input  logic [NPORTS*4-1:0]      wen,
  input  logic [NPORTS*32-1:0]     addr,
  input  logic [NPORTS*32-1:0]     store,
  output logic [NPORTS*32-1:0]     load,
  output ram_state_t [NPORTS-1:0]  state
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int AW = $clog2(RAM_SIZE);
  localparam int CW = $clog2(LAT + 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(LAT);

  ctrl_state_t   fsm_q, fsm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] gnt_q, gnt_d;
  logic [PW-1:0] gnt;
  logic [NPORTS-1:0] req;
  logic          any_req;
  logic          issue;

  logic [3:0]    arr_we;
  logic [AW-1:0] arr_idx;
  logic [31:0]   arr_wdata;
  logic [31:0]   arr_rdata;
  logic          unused_addr_bits;

  // Requests are masked while in reset so status reads idle throughout.
  always_comb begin
    req = '0;
    for (int p = 0; p < NPORTS; p++) begin
      req[p] = nrst & (ren[p] | (|wen[p*4 +: 4]));
    end
  end
  assign any_req = |req;

`ifdef RAM_MPORT_FIXED_PRIO_EN
  always_comb begin
    gnt = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (req[i]) gnt = PW'(i);
    end
  end
`else
  logic [PW-1:0] ptr_q;
  logic          found;

  always_comb begin
    gnt   = ptr_q;
    found = 1'b0;
    for (int i = 1; i <= NPORTS; i++) begin
      if (!found && req[(int'(ptr_q) + i) % NPORTS]) begin
        gnt   = PW'((int'(ptr_q) + i) % NPORTS);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                    ptr_q <= PW'(NPORTS - 1);
    else if (fsm_q == CTRL_DONE)  ptr_q <= gnt_q;
  end
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fsm_q <= CTRL_IDLE;
      cnt_q <= '0;
      gnt_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      gnt_q <= gnt_d;
    end
  end

  // The issue cycle counts as the first of the LAT+1 access cycles, so with
  // LAT=0 the controller goes straight from the grant to DONE.
  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    gnt_d = gnt_q;
    issue = 1'b0;
    case (fsm_q)
      CTRL_IDLE: begin
        if (any_req) begin
          issue = 1'b1;
          gnt_d = gnt;
          cnt_d = CW'(1);
          fsm_d = (LAT == 0) ? CTRL_DONE : CTRL_BUSY;
        end
      end
      CTRL_BUSY: begin
        if (!req[gnt_q]) begin
          fsm_d = CTRL_IDLE;
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          fsm_d = CTRL_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CTRL_DONE: begin
        fsm_d = CTRL_IDLE;
        cnt_d = '0;
      end
      default: begin
        fsm_d = CTRL_IDLE;
        cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    arr_we    = '0;
    arr_idx   = '0;
    arr_wdata = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (gnt == PW'(p)) begin
        arr_we    = wen[p*4 +: 4];
        arr_idx   = addr[p*32 + 2 +: AW];
        arr_wdata = store[p*32 +: 32];
      end
    end
  end

  assign unused_addr_bits = ^addr;

  ram_mport_array #(
    .RAM_SIZE (RAM_SIZE),
    .LAT      (LAT)
  ) u_array (
    .clk     (clk),
    .en_i    (issue),
    .we_i    (arr_we),
    .idx_i   (arr_idx),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

  always_comb begin
    load = '0;
    for (int p = 0; p < NPORTS; p++) begin
      state[p] = RAM_IDLE;
      if (fsm_q == CTRL_DONE && gnt_q == PW'(p)) begin
        state[p]          = RAM_DONE;
        load[p*32 +: 32]  = arr_rdata;
      end else if (req[p]) begin
        state[p] = RAM_WAIT;
      end
    end
  end

endmodule
